// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing sequencer and its consumers.
// The master drives the raster position, syncs and strobes. The slave supplies the pixel tick and restart.
interface vga_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic          restart;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_end;
  logic          frame_end;

  modport master (
    input  en, restart,
    output x, y, hsync, vsync, active, line_end, frame_end
  );

  modport slave (
    output en, restart,
    input  x, y, hsync, vsync, active, line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: x/y pixel counters plus horizontal and vertical phase FSMs.
// Syncs and active are registered from the next FSM state, so they line up with x/y.
//
//   state   | meaning
//   PH_ACT  | visible region (x < H_ACTIVE / y < V_ACTIVE)
//   PH_FP   | front porch
//   PH_SYNC | sync pulse, sync output at SYNC_POL
//   PH_BP   | back porch, left when the counter wraps to 0
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master bus
);

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_B1   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_B2   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_B3   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_B1   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_B2   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_B3   = YW'(V_ACTIVE + V_FP + V_SYNC);

  // Zero-length phases are skipped by jumping straight to the next non-empty one.
  localparam phase_e H_AFTER_ACT = (H_FP != 0) ? PH_FP : (H_SYNC != 0) ? PH_SYNC : PH_BP;
  localparam phase_e H_AFTER_FP  = (H_SYNC != 0) ? PH_SYNC : PH_BP;
  localparam phase_e V_AFTER_ACT = (V_FP != 0) ? PH_FP : (V_SYNC != 0) ? PH_SYNC : PH_BP;
  localparam phase_e V_AFTER_FP  = (V_SYNC != 0) ? PH_SYNC : PH_BP;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  phase_e        h_state_q, h_state_d;
  phase_e        v_state_q, v_state_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          line_end;
  logic          frame_end;

  assign line_end  = bus.en && (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      h_state_q <= PH_ACT;
      v_state_q <= PH_ACT;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      active_q  <= 1'b1;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.restart) begin
      x_d = '0;
      y_d = '0;
    end else if (bus.en) begin
      x_d = line_end ? '0 : x_q + XW'(1);
      if (line_end) y_d = frame_end ? '0 : y_q + YW'(1);
    end
  end

  // Both FSMs look at the next counter value so the state matches the pixel shown.
  always_comb begin
    h_state_d = h_state_q;
    if (bus.restart) begin
      h_state_d = PH_ACT;
    end else if (bus.en) begin
      if (x_d == '0) begin
        h_state_d = PH_ACT;
      end else begin
        case (h_state_q)
          PH_ACT:  if (x_d == H_B1) h_state_d = H_AFTER_ACT;
          PH_FP:   if (x_d == H_B2) h_state_d = H_AFTER_FP;
          PH_SYNC: if (x_d == H_B3) h_state_d = PH_BP;
          PH_BP:   h_state_d = PH_BP;
          default: h_state_d = PH_ACT;
        endcase
      end
    end
  end

  always_comb begin
    v_state_d = v_state_q;
    if (bus.restart) begin
      v_state_d = PH_ACT;
    end else if (line_end) begin
      if (y_d == '0) begin
        v_state_d = PH_ACT;
      end else begin
        case (v_state_q)
          PH_ACT:  if (y_d == V_B1) v_state_d = V_AFTER_ACT;
          PH_FP:   if (y_d == V_B2) v_state_d = V_AFTER_FP;
          PH_SYNC: if (y_d == V_B3) v_state_d = PH_BP;
          PH_BP:   v_state_d = PH_BP;
          default: v_state_d = PH_ACT;
        endcase
      end
    end else if (bus.en) begin
      if (!(v_state_q inside {PH_ACT, PH_FP, PH_SYNC, PH_BP})) v_state_d = PH_ACT;
    end
  end

  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    if (bus.restart || bus.en) begin
      hsync_d  = (h_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = (v_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      active_d = (h_state_d == PH_ACT) && (v_state_d == PH_ACT);
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.active    = active_q;
  assign bus.line_end  = line_end;
  assign bus.frame_end = frame_end;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 instance plus a tiny instance with empty phases,
// both checked every cycle against a position-based raster model.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_if #(.XW(10), .YW(10)) bus0 ();
  vga_timing_if #(.XW(10), .YW(10)) bus1 ();

  vga_timing_ctrl #(.XW(10), .YW(10)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0),
    .XW(10), .YW(10), .SYNC_POL(1'b1)
  ) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  int ha[2]  = '{640, 8};
  int hfp[2] = '{16, 0};
  int hs[2]  = '{96, 3};
  int hb[2]  = '{48, 2};
  int va[2]  = '{480, 4};
  int vfp[2] = '{10, 1};
  int vs[2]  = '{2, 1};
  int vb[2]  = '{33, 0};
  bit pol[2] = '{1'b0, 1'b1};

  int mx[2], my[2];
  int n_cmp = 0;
  int n_err = 0;
  bit cur_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit e, input bit r);
    cur_en      = e;
    bus0.en     = e;
    bus1.en     = e;
    bus0.restart = r;
    bus1.restart = r;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0;
      my[d] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit r);
    for (int d = 0; d < 2; d++) begin
      int ht, vt;
      ht = ha[d] + hfp[d] + hs[d] + hb[d];
      vt = va[d] + vfp[d] + vs[d] + vb[d];
      if (r) begin
        mx[d] = 0;
        my[d] = 0;
      end else if (e) begin
        mx[d] = mx[d] + 1;
        if (mx[d] == ht) begin
          mx[d] = 0;
          my[d] = (my[d] + 1) % vt;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int ht, vt, hs0, vs0;
      bit e_hs, e_vs, e_act, e_le, e_fe;
      logic [9:0] ox, oy;
      logic oh, ov, oa, ol, of;
      ht  = ha[d] + hfp[d] + hs[d] + hb[d];
      vt  = va[d] + vfp[d] + vs[d] + vb[d];
      hs0 = ha[d] + hfp[d];
      vs0 = va[d] + vfp[d];
      e_hs  = (mx[d] >= hs0 && mx[d] < hs0 + hs[d]) ? pol[d] : !pol[d];
      e_vs  = (my[d] >= vs0 && my[d] < vs0 + vs[d]) ? pol[d] : !pol[d];
      e_act = (mx[d] < ha[d]) && (my[d] < va[d]);
      e_le  = cur_en && (mx[d] == ht - 1);
      e_fe  = e_le && (my[d] == vt - 1);
      if (d == 0) begin
        ox = bus0.x; oy = bus0.y; oh = bus0.hsync; ov = bus0.vsync;
        oa = bus0.active; ol = bus0.line_end; of = bus0.frame_end;
      end else begin
        ox = bus1.x; oy = bus1.y; oh = bus1.hsync; ov = bus1.vsync;
        oa = bus1.active; ol = bus1.line_end; of = bus1.frame_end;
      end
      check($sformatf("d%0d x", d),         32'(ox), 32'(mx[d]));
      check($sformatf("d%0d y", d),         32'(oy), 32'(my[d]));
      check($sformatf("d%0d hsync", d),     32'(oh), 32'(e_hs));
      check($sformatf("d%0d vsync", d),     32'(ov), 32'(e_vs));
      check($sformatf("d%0d active", d),    32'(oa), 32'(e_act));
      check($sformatf("d%0d line_end", d),  32'(ol), 32'(e_le));
      check($sformatf("d%0d frame_end", d), 32'(of), 32'(e_fe));
    end
  endtask

  task automatic cycle(input bit e, input bit r);
    @(negedge clk);
    drive(e, r);
    #1;
    check_all();
    model_step(e, r);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    model_reset();
    #12;
    check_all();

    // Free-running pixel tick for three default lines; tiny instance covers many frames.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2400; i++) cycle(1'b1, 1'b0);

    // Pixel tick every 4th clock.
    for (int i = 0; i < 1000; i++) cycle((i % 4) == 0, 1'b0);

    // Random tick and occasional restart.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);

    // Restart together with en at x=700.
    for (int i = 0; i < 900 && mx[0] != 700; i++) cycle(1'b1, 1'b0);
    check("reach x700", 32'(mx[0]), 32'd700);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);

    // Asynchronous reset in the middle of horizontal sync.
    for (int i = 0; i < 900 && mx[0] != 700; i++) cycle(1'b1, 1'b0);
    check("hsync before reset", 32'(bus0.hsync), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    #1;
    check_all();
    model_step(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
